// File: rtl/microtile_arb_pkg.sv
// Shared types and helpers for the microtile slot arbiter: FSM state encoding,
// tile bus width and the rotating-priority pick used by rr_priority_picker.
package microtile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam int TILE_W    = 8;
  localparam int MAX_TILES = 8;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pick_t;

  // Rotate the request vector so rr_ptr sits at position 0, take the lowest
  // set bit, then map that position back to a tile index modulo n.
  function automatic pick_t rr_pick(input logic [MAX_TILES-1:0] req,
                                    input logic [2:0]           rr_ptr,
                                    input int                   n);
    pick_t p;
    int    src;
    p = '0;
    for (int k = 0; k < MAX_TILES; k++) begin
      src = int'(rr_ptr) + k;
      if (src >= n) src = src - n;
      if (k < n && !p.valid && req[src[2:0]]) begin
        p.valid = 1'b1;
        p.idx   = src[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requesting tile at or after ptr,
// wrapping modulo NUM_TILES.
module rr_priority_picker
  import microtile_arb_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int IDX_W     = $clog2(NUM_TILES)
) (
  input  logic [NUM_TILES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 valid,
  output logic [IDX_W-1:0]     idx
);

  pick_t pick;

  always_comb begin
    pick  = rr_pick(MAX_TILES'(req), 3'(ptr), NUM_TILES);
    valid = pick.valid;
    idx   = IDX_W'(pick.idx);
  end

endmodule

// File: rtl/microtile_slot_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit output between NUM_TILES
// microtiles. Optional per-tile grant counters under MTILE_ARB_STATS_EN.
module microtile_slot_arbiter
  import microtile_arb_pkg::*;
#(
  parameter int NUM_TILES = 4,
  parameter int MAX_HOLD  = 16,
  parameter int IDX_W     = $clog2(NUM_TILES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_TILES-1:0]        req,
  input  logic [TILE_W*NUM_TILES-1:0] tile_uo,
  output logic [NUM_TILES-1:0]        gnt,
  output logic [IDX_W-1:0]            gnt_idx,
  output logic [7:0]                  uo_out,
  output logic                        uo_valid
`ifdef MTILE_ARB_STATS_EN
  ,
  output logic [16*NUM_TILES-1:0]     grant_count
`endif
);

  localparam int HOLD_W = $clog2(MAX_HOLD);

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic               grant_done;

  rr_priority_picker #(
    .NUM_TILES (NUM_TILES),
    .IDX_W     (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Owner dropped its request, or this is the last cycle it may hold the bus.
  assign grant_done = !req[gnt_idx] || (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld)   state_nxt = GRANT;
      GRANT:   if (grant_done) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt = '0;
    if (state == GRANT) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) gnt_idx <= pick_idx;
          hold_cnt <= '0;
        end
        GRANT:   hold_cnt <= hold_cnt + HOLD_W'(1);
        RELEASE: rr_ptr <= (gnt_idx == IDX_W'(NUM_TILES - 1)) ? '0 : gnt_idx + IDX_W'(1);
        default: hold_cnt <= '0;
      endcase
    end
  end

  // Output stage: one-cycle registered copy of the granted tile's bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out   <= 8'h00;
      uo_valid <= 1'b0;
    end else if (state == GRANT) begin
      uo_out   <= tile_uo[TILE_W*gnt_idx +: TILE_W];
      uo_valid <= 1'b1;
    end else begin
      uo_out   <= 8'h00;
      uo_valid <= 1'b0;
    end
  end

`ifdef MTILE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
    end else if (state == IDLE && pick_vld) begin
      for (int i = 0; i < NUM_TILES; i++) begin
        if (pick_idx == IDX_W'(i) && grant_count[16*i +: 16] != 16'hFFFF)
          grant_count[16*i +: 16] <= grant_count[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_microtile_slot_arbiter.sv
// Self-checking bench for microtile_slot_arbiter: directed scenarios followed by
// randomized traffic, all checked every cycle against a behavioural grant model.
module tb_microtile_slot_arbiter;

  localparam int N  = 4;
  localparam int H  = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] tile_uo;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  gnt_idx;
  logic [7:0]     uo_out;
  logic           uo_valid;
`ifdef MTILE_ARB_STATS_EN
  logic [16*N-1:0] grant_count;
`endif

  always #5 clk = ~clk;

  microtile_slot_arbiter #(
    .NUM_TILES (N),
    .MAX_HOLD  (H),
    .IDX_W     (IW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .tile_uo  (tile_uo),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .uo_out   (uo_out),
    .uo_valid (uo_valid)
`ifdef MTILE_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: who owns the bus, how long they have had it, and
  // whether the one-cycle turnaround is pending.
  int         m_owner = -1;
  int         m_last  = 0;
  int         m_ptr   = 0;
  int         m_held  = 0;
  bit         m_turn  = 1'b0;
  logic [7:0] m_uo    = 8'h00;
  bit         m_vld   = 1'b0;
  int         m_cnt[N];
  bit         force_a5 = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] nuo;
    bit         nvld;
    nvld = (m_owner >= 0);
    nuo  = nvld ? tile_uo[m_owner*8 +: 8] : 8'h00;
    if (rst) begin
      m_owner = -1; m_turn = 1'b0; m_ptr = 0; m_held = 0; m_last = 0;
      m_uo = 8'h00; m_vld = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      return;
    end
    m_uo  = nuo;
    m_vld = nvld;
    if (m_owner >= 0) begin
      m_held++;
      if (!req[m_owner] || m_held == H) begin
        m_owner = -1;
        m_turn  = 1'b1;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
      m_ptr  = (m_last + 1) % N;
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (req[c]) begin
          m_owner = c;
          m_last  = c;
          m_held  = 0;
          if (m_cnt[c] < 65535) m_cnt[c]++;
          break;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("gnt",      64'(gnt),      64'(eg));
    chk("gnt_idx",  64'(gnt_idx),  64'(m_last));
    chk("uo_out",   64'(uo_out),   64'(m_uo));
    chk("uo_valid", 64'(uo_valid), 64'(m_vld));
    chk("onehot0",  64'($onehot0(gnt)), 64'd1);
`ifdef MTILE_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk("grant_count", 64'(grant_count[16*i +: 16]), 64'(m_cnt[i]));
`endif
  endtask

  task automatic cycle(input bit r, input logic [N-1:0] q);
    @(negedge clk);
    rst     = r;
    req     = q;
    tile_uo = $urandom;
    if (force_a5) tile_uo[23:16] = 8'hA5;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] prev;
    int           k;
    int           run;

    rst = 1'b1; req = '0; tile_uo = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;

    // Reset held with every tile requesting.
    repeat (3) begin
      cycle(1'b1, 4'b1111);
      chk("rst_gnt",   64'(gnt),      64'd0);
      chk("rst_valid", 64'(uo_valid), 64'd0);
      chk("rst_uo",    64'(uo_out),   64'd0);
    end
    cycle(1'b0, 4'b1111);
    chk("first_gnt", 64'(gnt), 64'b0001);
    repeat (4) cycle(1'b0, 4'b0000);

    // Single requester on tile 2 with a fixed data pattern.
    force_a5 = 1'b1;
    repeat (3) cycle(1'b0, 4'b0100);
    chk("single_gnt", 64'(gnt), 64'b0100);
    cycle(1'b0, 4'b0000);
    chk("single_rel", 64'(gnt),      64'd0);
    chk("single_uo",  64'(uo_out),   64'hA5);
    chk("single_vld", 64'(uo_valid), 64'd1);
    cycle(1'b0, 4'b0000);
    chk("single_vld_fall", 64'(uo_valid), 64'd0);
    force_a5 = 1'b0;
    repeat (3) cycle(1'b0, 4'b0000);

    // All tiles requesting: rotation continues from the tile after 2.
    prev = '0; k = 0;
    repeat (80) begin
      cycle(1'b0, 4'b1111);
      if (gnt != 0 && prev == 0) begin
        chk("rr_order", 64'(gnt_idx), 64'((3 + k) % N));
        k++;
      end
      prev = gnt;
    end
    repeat (20) cycle(1'b0, 4'b0000);

    // Continuous request from tile 0: forced release after H cycles.
    run = 0;
    repeat (60) begin
      cycle(1'b0, 4'b0001);
      if (gnt[0]) run++;
      else if (run != 0) begin
        chk("hold_len", 64'(run), 64'(H));
        run = 0;
      end
    end
    repeat (20) cycle(1'b0, 4'b0000);

    // Reset during the fifth grant cycle of tile 3.
    repeat (5) cycle(1'b0, 4'b1000);
    chk("mid_gnt", 64'(gnt), 64'b1000);
    cycle(1'b1, 4'b1000);
    chk("mid_rst_gnt", 64'(gnt),      64'd0);
    chk("mid_rst_vld", 64'(uo_valid), 64'd0);
    chk("mid_rst_uo",  64'(uo_out),   64'd0);
    cycle(1'b0, 4'b1111);
    chk("mid_rst_next", 64'(gnt), 64'b0001);

    // Randomized traffic with sticky requests and rare resets.
    rq = '0;
    repeat (3000) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      cycle($urandom_range(0, 299) == 0, rq);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
